// File: rtl/ula_unit.sv
// ula_unit: 8-bit ALU for the REDUX-V datapath.
// Combinational result plus a registered status-flag set for branches.
module ula_unit #(
  parameter int BITS = 8,
  parameter int OP   = 4
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [BITS-1:0] a_in,
  input  logic [BITS-1:0] b_in,
  input  logic [OP-1:0]   op_in,
  input  logic            flags_we_in,
  output logic [BITS-1:0] result_out,
  output logic            zero_out,
  output logic            carry_out,
  output logic            neg_out,
  output logic            ovf_out
);

  localparam int SHW = $clog2(BITS);

  localparam logic [OP-1:0] OP_ADD   = OP'(0);
  localparam logic [OP-1:0] OP_SUB   = OP'(1);
  localparam logic [OP-1:0] OP_AND   = OP'(2);
  localparam logic [OP-1:0] OP_OR    = OP'(3);
  localparam logic [OP-1:0] OP_XOR   = OP'(4);
  localparam logic [OP-1:0] OP_NOT   = OP'(5);
  localparam logic [OP-1:0] OP_SLL   = OP'(6);
  localparam logic [OP-1:0] OP_SRL   = OP'(7);
  localparam logic [OP-1:0] OP_SRA   = OP'(8);
  localparam logic [OP-1:0] OP_SLT   = OP'(9);
  localparam logic [OP-1:0] OP_SLTU  = OP'(10);
  localparam logic [OP-1:0] OP_PASSB = OP'(11);
  localparam logic [OP-1:0] OP_MUL   = OP'(12);

  localparam logic [BITS-1:0] BITS_V = BITS'(BITS);

  logic [BITS:0]     sum;
  logic [BITS:0]     diff;
  logic [2*BITS-1:0] prod;
  logic [SHW-1:0]    shamt;
  logic              sh_big;
  logic              a_s;
  logic              b_s;
  logic              slt;
  logic              sltu;
  logic [BITS-1:0]   sll_r;
  logic [BITS-1:0]   srl_r;
  logic [BITS-1:0]   sra_r;
  logic [BITS-1:0]   res;
  logic              c_calc;
  logic              v_calc;

  assign sum   = {1'b0, a_in} + {1'b0, b_in};
  assign diff  = {1'b0, a_in} - {1'b0, b_in};
  assign prod  = a_in * b_in;
  assign a_s   = a_in[BITS-1];
  assign b_s   = b_in[BITS-1];
  assign sltu  = diff[BITS];
  assign slt   = (a_s != b_s) ? a_s : diff[BITS];

  // Whole b is the amount; anything >= BITS shifts everything out.
  assign shamt  = b_in[SHW-1:0];
  assign sh_big = (b_in >= BITS_V);

  assign sll_r = sh_big ? '0 : (a_in << shamt);
  assign srl_r = sh_big ? '0 : (a_in >> shamt);
  assign sra_r = sh_big ? {BITS{a_s}}
                        : BITS'($signed(a_in) >>> shamt);

  always_comb begin
    res    = '0;
    c_calc = 1'b0;
    v_calc = 1'b0;
    unique case (op_in)
      OP_ADD: begin
        res    = sum[BITS-1:0];
        c_calc = sum[BITS];
        v_calc = (a_s == b_s) && (sum[BITS-1] != a_s);
      end
      OP_SUB: begin
        res    = diff[BITS-1:0];
        c_calc = diff[BITS];
        v_calc = (a_s != b_s) && (diff[BITS-1] != a_s);
      end
      OP_AND:   res = a_in & b_in;
      OP_OR:    res = a_in | b_in;
      OP_XOR:   res = a_in ^ b_in;
      OP_NOT:   res = ~a_in;
      OP_SLL:   res = sll_r;
      OP_SRL:   res = srl_r;
      OP_SRA:   res = sra_r;
      OP_SLT:   res = {{(BITS-1){1'b0}}, slt};
      OP_SLTU:  res = {{(BITS-1){1'b0}}, sltu};
      OP_PASSB: res = b_in;
      OP_MUL:   res = prod[BITS-1:0];
      default:  res = '0;
    endcase
  end

  assign result_out = res;

  logic zero_q, zero_d;
  logic carry_q, carry_d;
  logic neg_q, neg_d;
  logic ovf_q, ovf_d;

  always_comb begin
    zero_d  = zero_q;
    carry_d = carry_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    if (flags_we_in) begin
      zero_d  = (res == '0);
      carry_d = c_calc;
      neg_d   = res[BITS-1];
      ovf_d   = v_calc;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign zero_out  = zero_q;
  assign carry_out = carry_q;
  assign neg_out   = neg_q;
  assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_ula_unit.sv
// tb_ula_unit: vector table, exhaustive SRL sweep and flag-register
// sequences for ula_unit, with a queue of expected results.
module tb_ula_unit;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] op;
  logic       we;
  logic [7:0] result;
  logic       z, c, n, v;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] fl;
  } vec_t;

  vec_t vecs[22];
  vec_t sb[$];
  vec_t e;

  ula_unit #(.BITS(8), .OP(4)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .a_in(a),
    .b_in(b),
    .op_in(op),
    .flags_we_in(we),
    .result_out(result),
    .zero_out(z),
    .carry_out(c),
    .neg_out(n),
    .ovf_out(v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] fl();
    return {z, c, n, v};
  endfunction

  task automatic drive(input logic [3:0] o, input logic [7:0] x,
                       input logic [7:0] y);
    op = o;
    a  = x;
    b  = y;
  endtask

  initial begin
    // {op, a, b, result, {zero,carry,neg,ovf}}
    vecs[0]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 4'b1100};
    vecs[1]  = '{4'd0,  8'h7F, 8'h01, 8'h80, 4'b0011};
    vecs[2]  = '{4'd1,  8'h00, 8'h01, 8'hFF, 4'b0110};
    vecs[3]  = '{4'd1,  8'h80, 8'h01, 8'h7F, 4'b0001};
    vecs[4]  = '{4'd6,  8'h01, 8'd7,  8'h80, 4'b0010};
    vecs[5]  = '{4'd6,  8'h5A, 8'd200,8'h00, 4'b1000};
    vecs[6]  = '{4'd8,  8'h80, 8'd3,  8'hF0, 4'b0010};
    vecs[7]  = '{4'd8,  8'h80, 8'd255,8'hFF, 4'b0010};
    vecs[8]  = '{4'd2,  8'hF0, 8'h3C, 8'h30, 4'b0000};
    vecs[9]  = '{4'd5,  8'h0F, 8'h55, 8'hF0, 4'b0010};
    vecs[10] = '{4'd9,  8'hFF, 8'h01, 8'h01, 4'b0000};
    vecs[11] = '{4'd10, 8'hFF, 8'h01, 8'h00, 4'b1000};
    vecs[12] = '{4'd14, 8'h12, 8'h34, 8'h00, 4'b1000};
    vecs[13] = '{4'd3,  8'h0F, 8'h30, 8'h3F, 4'b0000};
    vecs[14] = '{4'd4,  8'hFF, 8'h0F, 8'hF0, 4'b0010};
    vecs[15] = '{4'd11, 8'h11, 8'hA5, 8'hA5, 4'b0010};
    vecs[16] = '{4'd12, 8'h10, 8'h11, 8'h10, 4'b0000};
    vecs[17] = '{4'd12, 8'hFF, 8'hFF, 8'h01, 4'b0000};
    vecs[18] = '{4'd7,  8'hF0, 8'd4,  8'h0F, 4'b0000};
    vecs[19] = '{4'd8,  8'h40, 8'd1,  8'h20, 4'b0000};
    vecs[20] = '{4'd0,  8'h80, 8'h80, 8'h00, 4'b1101};
    vecs[21] = '{4'd9,  8'h01, 8'hFF, 8'h00, 4'b1000};

    rst = 1'b1;
    we  = 1'b0;
    drive(4'd0, 8'h00, 8'h00);
    #12;
    chk("reset_flags", 32'(fl()), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      we = 1'b1;
      sb.push_back(vecs[i]);
      #1;
      e = sb.pop_front();
      chk($sformatf("res[%0d]", i), 32'(result), 32'(e.res));
      @(posedge clk);
      #1;
      chk($sformatf("flags[%0d]", i), 32'(fl()), 32'(e.fl));
    end

    @(negedge clk);
    we = 1'b0;
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 0; bi < 256; bi++) begin
        vec_t s;
        logic [7:0] ex;
        ex = 8'(ai);
        if (bi >= 8) ex = 8'h00;
        else for (int k = 0; k < bi; k++) ex = {1'b0, ex[7:1]};
        drive(4'd7, 8'(ai), 8'(bi));
        s = '{4'd7, 8'(ai), 8'(bi), ex, 4'b0000};
        sb.push_back(s);
        #1;
        e = sb.pop_front();
        if (result !== e.res) begin
          chk($sformatf("srl a=%0h b=%0h", e.a, e.b),
              32'(result), 32'(e.res));
        end else begin
          total++;
        end
      end
    end

    // Capture, then change inputs with write disabled: flags hold.
    @(negedge clk);
    drive(4'd0, 8'h7F, 8'h01);
    we = 1'b1;
    @(posedge clk);
    #1;
    chk("cap_flags", 32'(fl()), 32'b0011);
    @(negedge clk);
    we = 1'b0;
    drive(4'd0, 8'hFF, 8'h01);
    @(posedge clk);
    #1;
    chk("hold_flags", 32'(fl()), 32'b0011);
    chk("hold_res", 32'(result), 32'h00);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_flags", 32'(fl()), 32'h0);
    chk("async_rst_res", 32'(result), 32'h00);

    // Reset held across an edge with write enabled.
    we = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_dominates", 32'(fl()), 32'h0);

    // Release; no capture until an edge with write enabled.
    @(negedge clk);
    we  = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_hold", 32'(fl()), 32'h0);
    @(negedge clk);
    we = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_cap", 32'(fl()), 32'b1100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ula_unit.md
# ula_unit

8-bit arithmetic/logic unit of the REDUX-V datapath. It computes a combinational result from two operands and an operation code. It also holds a registered status-flag set that the control unit consumes for conditional branches. The block sits between the register-file read ports and the write-back mux.

## Interface
Parameters:
- BITS, 8, operand/result width (from `utils.vh`)
- OP, 4, operation-code width (from `utils.vh`)

Ports:
- clk_in  input  1  system clock; one clock, rising-edge
- rst_in  input  1  reset, asynchronous, active-high
- a_in  input  BITS  operand A
- b_in  input  BITS  operand B; also the shift amount for shifts
- op_in  input  OP  operation select
- flags_we_in  input  1  capture current flags at the next rising edge
- result_out  output  BITS  combinational result
- zero_out  output  1  registered zero flag
- carry_out  output  1  registered carry/borrow flag
- neg_out  output  1  registered negative flag (result MSB)
- ovf_out  output  1  registered signed-overflow flag

## Operation
op_in encodings; all arithmetic is modulo 2^BITS:
- 0 ADD: a+b; carry = bit 8 of the 9-bit sum
- 1 SUB: a−b; carry = 1 when a<b unsigned (borrow)
- 2 AND: a&b
- 3 OR: a|b
- 4 XOR: a^b
- 5 NOT: ~a; b ignored
- 6 SLL: a<<b. b is the full 8-bit unsigned amount; b≥8 gives 0.
- 7 SRL: a>>b, logical with zero fill. b is the full 8-bit amount; b≥8 gives 0. b=0 gives a.
- 8 SRA: arithmetic right shift of a by b. b≥8 gives 8'hFF if a[7]=1, else 0.
- 9 SLT: 1 if signed a<signed b, else 0
- 10 SLTU: 1 if unsigned a<b, else 0
- 11 PASSB: b
- 12 MUL: low 8 bits of a*b
- 13–15: result 0

Flag rules:
- Carry is 0 for every op except ADD and SUB.
- Overflow (ADD and SUB only, else 0):
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from a.
- Zero = (result==0).
- Negative = result[7].
- result_out never depends on clk_in, rst_in, flags_we_in, or the flag registers.

## Timing
- result_out is purely combinational with zero latency. It must settle within the same timestep as any a_in/b_in/op_in change; the bench checks it after a #1 delay.
- Flag registers:
  - On rising clk_in with flags_we_in=1, capture the flags computed from the current inputs.
  - With flags_we_in=0, hold the previous value.
- rst_in asserted forces zero_out, carry_out, neg_out and ovf_out to 0 immediately, independent of the clock.
  - Reset dominates a simultaneous clock edge with flags_we_in=1.
  - Reset does not affect result_out.
- Deasserting rst_in mid-operation: the first capture occurs at the next rising edge with flags_we_in=1.

## Test plan
- Exhaustive SRL, op=7: all 256×256 a,b pairs; result_out == a>>b each step. Examples: a=0xF0,b=4 → 0x0F; a=0x80,b=8 → 0x00; a=0xAB,b=0 → 0xAB.
- ADD/SUB edges:
  - 0xFF+0x01 → result 0x00; zero=1, carry=1 captured.
  - 0x7F+0x01 → result 0x80; ovf=1, neg=1.
  - 0x00−0x01 → result 0xFF; carry=1.
- Shift boundaries:
  - SLL 0x01 by 7 → 0x80.
  - SLL by 200 → 0x00.
  - SRA 0x80 by 3 → 0xF0.
  - SRA 0x80 by 255 → 0xFF.
- Logic and compare:
  - AND 0xF0,0x3C → 0x30.
  - NOT 0x0F → 0xF0.
  - SLT 0xFF,0x01 → 1.
  - SLTU 0xFF,0x01 → 0.
  - op=14 → 0x00.
- Flag register:
  - Capture with flags_we_in=1, then change inputs with flags_we_in=0 → flags hold.
  - Assert rst_in between clock edges → all flags 0 immediately; result_out unchanged.
